// File: rtl/pcie_tx_layer_nch.sv
// pcie_tx_layer_nch: NUM_CH virtual-channel transmit datapath with controller FSM
module pcie_tx_layer_nch #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_CH     = 2,
    parameter int MAIN_DEPTH = 8,
    parameter int VC_DEPTH   = 16,
    parameter int D_DEPTH    = 4,
    parameter int TH_W       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic                         wr_enable,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [TH_W-1:0]              umbral_main,
    input  logic [TH_W-1:0]              umbral_vc,
    input  logic [TH_W-1:0]              umbral_d,
    input  logic [NUM_CH-1:0]            pop_d,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out_d,
    output logic [NUM_CH-1:0]            empty_d,
    output logic [NUM_CH-1:0]            error_d,
    output logic                         pause_main,
    output logic [2:0]                   state_out,
    output logic                         idle_out,
    output logic                         active_out,
    output logic                         error_out
);
    localparam int DW   = DATA_WIDTH;
    localparam int CH_W = $clog2(NUM_CH);
    localparam int MA_W = $clog2(MAIN_DEPTH);
    localparam int VA_W = $clog2(VC_DEPTH);
    localparam int DA_W = $clog2(D_DEPTH);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t state, state_nx;
    logic [TH_W-1:0] th_main, th_vc, th_d;

    logic [DW-1:0]   main_mem [MAIN_DEPTH];
    logic [MA_W-1:0] main_rd, main_wr;
    logic [MA_W:0]   main_cnt;

    logic [DW-1:0]   vc_mem [NUM_CH][VC_DEPTH];
    logic [VA_W-1:0] vc_rd [NUM_CH];
    logic [VA_W-1:0] vc_wr [NUM_CH];
    logic [VA_W:0]   vc_cnt [NUM_CH];

    logic [DW-1:0]   d_mem [NUM_CH][D_DEPTH];
    logic [DA_W-1:0] d_rd [NUM_CH];
    logic [DA_W-1:0] d_wr [NUM_CH];
    logic [DA_W:0]   d_cnt [NUM_CH];

    logic              run, pop_ok, all_empty, err_ev;
    logic [DW-1:0]     main_head, grant_data;
    logic [CH_W-1:0]   main_cls, grant, rr_ptr;
    logic              main_af, main_full, main_pop, main_push, main_ovf, wr_acc, grant_vld;
    logic [DW-1:0]     vc_head [NUM_CH];
    logic [CH_W-1:0]   vc_dest [NUM_CH];
    logic [NUM_CH-1:0] vc_af, d_af, vc_push, vc_pop, d_push, d_pop, d_err, elig;

    function automatic logic almost_full(input int cnt, input int th, input int depth);
        return cnt + th >= depth;
    endfunction

    // Transfer decisions: gating, almost-full flags, round-robin grant
    always_comb begin
        run       = state == S_IDLE || state == S_ACTIVE;
        pop_ok    = state != S_RESET;
        main_head = main_mem[main_rd];
        main_cls  = main_head[DW-1 -: CH_W];
        main_af   = almost_full(int'(main_cnt), int'(th_main), MAIN_DEPTH);
        main_full = main_cnt == (MA_W+1)'(MAIN_DEPTH);
        all_empty = main_cnt == '0;
        for (int i = 0; i < NUM_CH; i++) begin
            vc_head[i] = vc_mem[i][vc_rd[i]];
            vc_dest[i] = vc_head[i][DW-1-CH_W -: CH_W];
            vc_af[i]   = almost_full(int'(vc_cnt[i]), int'(th_vc), VC_DEPTH);
            d_af[i]    = almost_full(int'(d_cnt[i]), int'(th_d), D_DEPTH);
            d_err[i]   = pop_ok && pop_d[i] && d_cnt[i] == '0;
            d_pop[i]   = pop_ok && pop_d[i] && d_cnt[i] != '0;
            all_empty  = all_empty && vc_cnt[i] == '0 && d_cnt[i] == '0;
        end
        for (int i = 0; i < NUM_CH; i++)
            elig[i] = run && vc_cnt[i] != '0 && !d_af[vc_dest[i]];
        grant     = rr_ptr;
        grant_vld = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (elig[rr_ptr + CH_W'(k)]) begin
                grant_vld = 1'b1;
                grant     = rr_ptr + CH_W'(k);
            end
        end
        grant_data = vc_head[grant];
        vc_pop     = grant_vld ? NUM_CH'(1) << grant : '0;
        d_push     = grant_vld ? NUM_CH'(1) << grant_data[DW-1-CH_W -: CH_W] : '0;
        main_pop   = run && main_cnt != '0 && !vc_af[main_cls];
        wr_acc     = run && wr_enable;
        main_ovf   = wr_acc && main_full && !main_pop;
        main_push  = wr_acc && !main_ovf;
        vc_push    = main_pop ? NUM_CH'(1) << main_cls : '0;
        err_ev     = main_ovf || |d_err;
    end

    // Controller next state; errors dominate, then init, then traffic
    always_comb begin
        state_nx = state;
        case (state)
            S_RESET:  state_nx = S_INIT;
            S_INIT:   state_nx = err_ev ? S_ERROR : init ? S_INIT : S_IDLE;
            S_IDLE:   state_nx = err_ev ? S_ERROR : init ? S_INIT : wr_acc ? S_ACTIVE : S_IDLE;
            S_ACTIVE: state_nx = err_ev ? S_ERROR : init ? S_INIT :
                                 (all_empty && !wr_enable) ? S_IDLE : S_ACTIVE;
            default:  state_nx = S_ERROR;
        endcase
    end

    // Status outputs and show-ahead D heads (zero while empty)
    always_comb begin
        data_out_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            empty_d[i]             = d_cnt[i] == '0;
            data_out_d[i*DW +: DW] = empty_d[i] ? '0 : d_mem[i][d_rd[i]];
        end
        pause_main = main_af;
        state_out  = state;
        idle_out   = state == S_IDLE;
        active_out = state == S_ACTIVE;
        error_out  = state == S_ERROR;
    end

    // Controller state and thresholds latched only while held in INIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_RESET;
            th_main <= '0;
            th_vc   <= '0;
            th_d    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_INIT && init) begin
                th_main <= umbral_main;
                th_vc   <= umbral_vc;
                th_d    <= umbral_d;
            end
        end
    end

    // FIFO pointers, counters, sticky pop errors and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_rd  <= '0;
            main_wr  <= '0;
            main_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                vc_rd[i]  <= '0;
                vc_wr[i]  <= '0;
                vc_cnt[i] <= '0;
                d_rd[i]   <= '0;
                d_wr[i]   <= '0;
                d_cnt[i]  <= '0;
            end
            error_d <= '0;
            rr_ptr  <= '0;
        end else begin
            if (main_push) main_wr <= main_wr + MA_W'(1);
            if (main_pop) main_rd <= main_rd + MA_W'(1);
            main_cnt <= main_cnt + (MA_W+1)'(main_push) - (MA_W+1)'(main_pop);
            for (int i = 0; i < NUM_CH; i++) begin
                if (vc_push[i]) vc_wr[i] <= vc_wr[i] + VA_W'(1);
                if (vc_pop[i]) vc_rd[i] <= vc_rd[i] + VA_W'(1);
                vc_cnt[i] <= vc_cnt[i] + (VA_W+1)'(vc_push[i]) - (VA_W+1)'(vc_pop[i]);
                if (d_push[i]) d_wr[i] <= d_wr[i] + DA_W'(1);
                if (d_pop[i]) d_rd[i] <= d_rd[i] + DA_W'(1);
                d_cnt[i] <= d_cnt[i] + (DA_W+1)'(d_push[i]) - (DA_W+1)'(d_pop[i]);
                if (d_err[i]) error_d[i] <= 1'b1;
            end
            if (grant_vld) rr_ptr <= grant + CH_W'(1);
        end
    end

    // FIFO storage, written at the tail pointers
    always_ff @(posedge clk) begin
        if (main_push) main_mem[main_wr] <= data_in;
        for (int i = 0; i < NUM_CH; i++) begin
            if (vc_push[i]) vc_mem[i][vc_wr[i]] <= main_head;
            if (d_push[i]) d_mem[i][d_wr[i]] <= grant_data;
        end
    end
endmodule
